// File: rtl/chunk_map_arbiter.sv
// chunk_map_arbiter
//   Owns the single-port synchronous chunk-map RAM (GRID_W x GRID_H tiles,
//   TYPE_W bits each). Render reads always win the port; game-logic writes
//   wait in a small FIFO that forwards to reads; a full-map clear is swept
//   one tile per cycle the port is free.
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   rd_req_i/rd_x_i/rd_y_i render read request and tile coordinates
//   rd_valid_o/rd_data_o   read result, one cycle after rd_req_i
//   wr_req_i/wr_x_i/wr_y_i/wr_data_i  logic write request
//   wr_ready_o             write queue not full
//   wr_err_o               accepted write had out-of-range coordinates
//   clr_req_i/clr_busy_o   start / in-progress full-map clear sweep
//   mem_*                  RAM port (mem_rdata_i valid one cycle after a read)
module chunk_map_arbiter #(
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 10,
    parameter int TYPE_W   = 4,
    parameter int WQ_DEPTH = 4,
    parameter int CLR_TYPE = 0,
    parameter int OOB_TYPE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_i,
    input  logic [3:0]        rd_x_i,
    input  logic [3:0]        rd_y_i,
    output logic              rd_valid_o,
    output logic [TYPE_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [3:0]        wr_x_i,
    input  logic [3:0]        wr_y_i,
    input  logic [TYPE_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              wr_err_o,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [6:0]        mem_addr_o,
    output logic [TYPE_W-1:0] mem_wdata_o,
    input  logic [TYPE_W-1:0] mem_rdata_i
);

    localparam int AW = 7;
    localparam int PW = $clog2(WQ_DEPTH);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(GRID_W * GRID_H - 1);
    localparam logic [PW:0]       DEPTH_C   = (PW + 1)'(WQ_DEPTH);
    localparam logic [TYPE_W-1:0] CLR_C     = TYPE_W'(CLR_TYPE);
    localparam logic [TYPE_W-1:0] OOB_C     = TYPE_W'(OOB_TYPE);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

    logic [AW-1:0]     wq_addr_q [WQ_DEPTH];
    logic [TYPE_W-1:0] wq_data_q [WQ_DEPTH];
    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d, fwd_idx;
    logic [PW:0]       cnt_q, cnt_d;

    logic              rd_valid_q, rd_mem_q, rd_mem_d;
    logic [TYPE_W-1:0] rd_imm_q, rd_imm_d, rd_hold_q, rd_hold_d;
    logic              wr_err_q;

    logic [AW-1:0]     rd_addr, wr_addr;
    logic              rd_oob, wr_oob, rd_hit, wr_acc, push, pop, sweep_go;
    logic              fwd_hit, unswept;
    logic [TYPE_W-1:0] fwd_data;

    assign rd_oob  = (rd_x_i >= 4'(GRID_W)) || (rd_y_i >= 4'(GRID_H));
    assign wr_oob  = (wr_x_i >= 4'(GRID_W)) || (wr_y_i >= 4'(GRID_H));
    assign rd_addr = AW'(rd_y_i) * AW'(GRID_W) + AW'(rd_x_i);
    assign wr_addr = AW'(wr_y_i) * AW'(GRID_W) + AW'(wr_x_i);

    assign rd_hit     = rd_req_i && !rd_oob;
    assign wr_ready_o = (cnt_q < DEPTH_C);
    assign wr_acc     = wr_req_i && wr_ready_o;
    assign push       = wr_acc && !wr_oob;
    assign sweep_go   = (state_q == ST_SWEEP) && !rd_hit;
    assign pop        = (state_q == ST_IDLE) && !rd_hit && (cnt_q != '0);
    assign unswept    = (state_q == ST_SWEEP) && (rd_addr >= clr_cnt_q);

    assign clr_busy_o = (state_q == ST_SWEEP);
    assign rd_valid_o = rd_valid_q;
    assign wr_err_o   = wr_err_q;
    assign rd_data_o  = rd_valid_q ? (rd_mem_q ? mem_rdata_i : rd_imm_q) : rd_hold_q;

    // Walk oldest to newest so the last match (newest entry) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            fwd_idx = rptr_q + PW'(i);
            if (((PW + 1)'(i) < cnt_q) && (wq_addr_q[fwd_idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wq_data_q[fwd_idx];
            end
        end
    end

    // Single RAM port: read, then sweep, then queue head.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (rd_hit) begin
            mem_en_o   = 1'b1;
            mem_addr_o = rd_addr;
        end else if (sweep_go) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = clr_cnt_q;
            mem_wdata_o = CLR_C;
        end else if (pop) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wq_addr_q[rptr_q];
            mem_wdata_o = wq_data_q[rptr_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE:  ;
            ST_SWEEP: begin
                if (sweep_go) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr_req_i) begin
            state_d   = ST_SWEEP;
            clr_cnt_d = '0;
        end
    end

    // A clear flushes everything queued so far; a write accepted in the same
    // cycle lands at the old write pointer, which becomes the new head.
    always_comb begin
        rptr_d = rptr_q + PW'(pop);
        wptr_d = wptr_q + PW'(push);
        cnt_d  = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        if (clr_req_i) begin
            rptr_d = wptr_q;
            cnt_d  = (PW + 1)'(push);
        end
    end

    always_comb begin
        rd_mem_d  = 1'b0;
        rd_imm_d  = rd_imm_q;
        rd_hold_d = rd_valid_q ? rd_data_o : rd_hold_q;
        if (rd_oob)       rd_imm_d = OOB_C;
        else if (fwd_hit) rd_imm_d = fwd_data;
        else if (unswept) rd_imm_d = CLR_C;
        else              rd_mem_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
                wq_addr_q[i] <= '0;
                wq_data_q[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_mem_q   <= 1'b0;
            rd_imm_q   <= '0;
            rd_hold_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            if (push) begin
                wq_addr_q[wptr_q] <= wr_addr;
                wq_data_q[wptr_q] <= wr_data_i;
            end
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_mem_q <= rd_mem_d;
                rd_imm_q <= rd_imm_d;
            end
            rd_hold_q  <= rd_hold_d;
            wr_err_q   <= wr_acc && wr_oob;
        end
    end

endmodule
